// File: rtl/alu_wb_pkg.sv
// Shared types and instruction-field layout for the ALU write-back sequencer.
// The optional multiplier is enabled by defining ALU_WB_MUL_EN (see alu_wb_alu).
package alu_wb_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_MOV = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_XOR = 4'h6,
        OP_NOT = 4'h7,
        OP_SHL = 4'h8,
        OP_SHR = 4'h9,
        OP_MUL = 4'hA,
        OP_LDI = 4'hB
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam int OP_W = 4;

    // Instruction word is {op, d, s0, s1}; offsets depend on the address width.
    function automatic int off_s1(input int aw);
        return 0;
    endfunction

    function automatic int off_s0(input int aw);
        return aw;
    endfunction

    function automatic int off_d(input int aw);
        return 2 * aw;
    endfunction

    function automatic int off_op(input int aw);
        return 3 * aw;
    endfunction

endpackage

// File: rtl/alu_wb_alu.sv
// Combinational opcode decode and ALU for the write-back sequencer.
// Opcode A is MUL only when ALU_WB_MUL_EN is defined; otherwise it decodes as a NOP.
module alu_wb_alu
    import alu_wb_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic [OP_W-1:0] op,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [2*AW-1:0] imm,
    output logic [DW-1:0]   result,
    output logic            carry,
    output logic            writes
);

`ifdef ALU_WB_MUL_EN
    logic [2*DW-1:0] prod;
`endif

    always_comb begin
        result = '0;
        carry  = 1'b0;
        writes = 1'b1;
`ifdef ALU_WB_MUL_EN
        prod   = '0;
`endif
        case (op)
            OP_MOV: result = a;
            OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[DW-2:0], 1'b0};
                carry  = a[DW-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DW-1:1]};
                carry  = a[0];
            end
`ifdef ALU_WB_MUL_EN
            OP_MUL: begin
                prod   = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
                result = prod[DW-1:0];
                carry  = |prod[2*DW-1:DW];
            end
`endif
            OP_LDI: result = imm[DW-1:0];
            default: writes = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_wb_seq.sv
// Execute/write-back sequencer in front of the register file: IDLE -> READ -> EXEC -> WB.
// Build option: ALU_WB_MUL_EN adds the MUL opcode in alu_wb_alu.
module alu_wb_seq
    import alu_wb_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W+3*AW-1:0] in_instr,
    output logic [AW-1:0]        src0,
    output logic [AW-1:0]        src1,
    input  logic [DW-1:0]        rf_data0,
    input  logic [DW-1:0]        rf_data1,
    output logic [AW-1:0]        dst,
    output logic [DW-1:0]        data,
    output logic                 we,
    output logic                 done,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic [1:0]           dbg_state
);

    localparam int OFF_OP = off_op(AW);
    localparam int OFF_D  = off_d(AW);
    localparam int OFF_S0 = off_s0(AW);
    localparam int OFF_S1 = off_s1(AW);

    // Handshake: an instruction transfers on a rising edge where in_valid && in_ready
    // and rst is low; in_ready is high exactly while the sequencer sits in IDLE.
    state_t          state;
    logic [OP_W-1:0] op_r;
    logic [AW-1:0]   d_r;
    logic [DW-1:0]   opa;
    logic [DW-1:0]   opb;
    logic            carry_r;
    logic            writes_r;

    logic [DW-1:0]   alu_result;
    logic            alu_carry;
    logic            alu_writes;

    assign in_ready  = (state == S_IDLE);
    assign dbg_state = state;

    alu_wb_alu #(.DW(DW), .AW(AW)) u_alu (
        .op     (op_r),
        .a      (opa),
        .b      (opb),
        .imm    ({src0, src1}),
        .result (alu_result),
        .carry  (alu_carry),
        .writes (alu_writes)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_r     <= '0;
            d_r      <= '0;
            src0     <= '0;
            src1     <= '0;
            opa      <= '0;
            opb      <= '0;
            carry_r  <= 1'b0;
            writes_r <= 1'b0;
            dst      <= '0;
            data     <= '0;
            we       <= 1'b0;
            done     <= 1'b0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r  <= in_instr[OFF_OP +: OP_W];
                        d_r   <= in_instr[OFF_D  +: AW];
                        src0  <= in_instr[OFF_S0 +: AW];
                        src1  <= in_instr[OFF_S1 +: AW];
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    opa   <= rf_data0;
                    opb   <= rf_data1;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    carry_r  <= alu_carry;
                    writes_r <= alu_writes;
                    if (alu_writes) begin
                        dst  <= d_r;
                        data <= alu_result;
                        we   <= 1'b1;
                    end
                    done  <= 1'b1;
                    state <= S_WB;
                end
                S_WB: begin
                    // Flags commit on the same edge the register file takes the write.
                    if (writes_r) begin
                        flag_z <= (data == '0);
                        flag_c <= carry_r;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
